// File: rtl/uart_rx_frame_if.sv
// Byte-side bundle of the UART receiver: the recovered byte, its strobes
// and the busy flag. The receiver drives it (master); the parser reads it (slave).
interface uart_rx_frame_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ferr;
   logic       rx_busy;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_ferr,
      output rx_busy
   );

   modport slave (
      input rx_data,
      input rx_valid,
      input rx_ferr,
      input rx_busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver. It oversamples rxd with the system clock, samples each bit
// at mid-bit, and presents each good byte with a one-clock rx_valid strobe.
// A low stop bit raises a one-clock rx_ferr strobe and drops the byte. The
// receiver then waits for the line to return high before it looks for a new start bit.
module uart_rx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 5
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             rxd,
   uart_rx_frame_if.master  rx
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   // Counter values at mid-start-bit and at the end of a full bit period.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       sync_reg;
   logic             rxd_s;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       idx_reg, idx_next;
   logic [7:0]       shreg_reg, shreg_next;
   logic [7:0]       data_reg, data_next;
   logic             valid_reg, valid_next;
   logic             ferr_reg, ferr_next;

   // Two-flop synchronizer for the asynchronous pin. It resets to the idle level.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) sync_reg <= 2'b11;
      else        sync_reg <= {sync_reg[0], rxd};
   end

   assign rxd_s = sync_reg[1];

   // State, bit-period counter, bit index, shift register and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shreg_reg <= '0;
         data_reg  <= '0;
         valid_reg <= 1'b0;
         ferr_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shreg_reg <= shreg_next;
         data_reg  <= data_next;
         valid_reg <= valid_next;
         ferr_reg  <= ferr_next;
      end
   end

   // Next-state logic. The start bit is confirmed half a bit in, so every
   // later sample lands at mid-bit. Leaving STOP at mid-stop-bit returns to
   // IDLE early enough to catch a start bit that directly follows the stop bit.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shreg_next = shreg_reg;
      data_next  = data_reg;
      valid_next = 1'b0;
      ferr_next  = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!rxd_s) begin
               state_next = START;
               cnt_next   = '0;
            end
         end

         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next = '0;
               if (!rxd_s) begin
                  state_next = DATA;
                  idx_next   = '0;
               end else begin
                  // The line went high again, so the low was a glitch.
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         DATA: begin
            if (cnt_reg == FULL_LAST) begin
               cnt_next   = '0;
               shreg_next = {rxd_s, shreg_reg[7:1]};
               idx_next   = idx_reg + 3'd1;
               if (idx_reg == 3'd7) state_next = STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         STOP: begin
            if (cnt_reg == FULL_LAST) begin
               cnt_next = '0;
               if (rxd_s) begin
                  data_next  = shreg_reg;
                  valid_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next  = 1'b1;
                  state_next = WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         WAIT_IDLE: begin
            // Stay here while the line is held low (break), so it cannot start a new frame.
            if (rxd_s) state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx.rx_data  = data_reg;
   assign rx.rx_valid = valid_reg;
   assign rx.rx_ferr  = ferr_reg;
   assign rx.rx_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 16 clocks per bit, 10-unit clock.
module tb_uart_rx_frame;

   localparam int CPB = 16;

   logic clk;
   logic n_rst;
   logic rxd;

   uart_rx_frame_if rx_if ();

   uart_rx_frame #(
      .CLKS_PER_BIT (CPB),
      .CNT_W        (5)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .rxd   (rxd),
      .rx    (rx_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int fall_cyc = 0;
   int last_lat = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int both_cnt = 0;
   int dbl_cnt = 0;
   logic prev_valid = 1'b0;
   logic [7:0] rx_log [$];

   logic [7:0] stream [14] = '{8'h49, 8'h20, 8'h53, 8'h20, 8'h66, 8'h66, 8'h66,
                               8'h35, 8'h2D, 8'h66, 8'h66, 8'h66, 8'h37, 8'h3D};

   // Rising-edge counter used to measure strobe latency.
   always @(posedge clk) cyc = cyc + 1;

   // Strobe monitor: logs every received byte and flags illegal strobe patterns.
   always @(negedge clk) begin
      if (rx_if.rx_valid === 1'b1) begin
         rx_log.push_back(rx_if.rx_data);
         valid_cnt = valid_cnt + 1;
         last_lat  = cyc - fall_cyc;
         if (prev_valid) dbl_cnt = dbl_cnt + 1;
      end
      if (rx_if.rx_ferr === 1'b1) ferr_cnt = ferr_cnt + 1;
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ferr === 1'b1) both_cnt = both_cnt + 1;
      prev_valid = (rx_if.rx_valid === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("  ok %s = %0h", tag, obs);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame LSB-first, starting on a falling clock edge. stop_bit selects the stop level.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      fall_cyc = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   // Waits, within a bounded number of clocks, until the valid count reaches target.
   task automatic wait_count(input string tag, input int target);
      int n;
      n = 0;
      while (valid_cnt < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      check(tag, valid_cnt, target);
   endtask

   int base;
   int ferr0;
   int n;

   initial begin
      n_rst = 1'b0;
      rxd   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", {24'h0, rx_if.rx_data}, 32'h00);
      check("reset_valid", rx_if.rx_valid, 1'b0);
      check("reset_ferr", rx_if.rx_ferr, 1'b0);
      check("reset_busy", rx_if.rx_busy, 1'b0);
      n_rst = 1'b1;
      idle(10);

      // A single 'I'.
      send_byte(8'h49, 1'b1);
      idle(20);
      wait_count("single_count", 1);
      check("single_data", {24'h0, rx_if.rx_data}, 32'h49);
      check("single_ferr", ferr_cnt, 0);

      // The calculator command stream, sent back-to-back.
      base = valid_cnt;
      for (int i = 0; i < 14; i++) send_byte(stream[i], 1'b1);
      idle(20);
      wait_count("stream_count", base + 14);
      for (int i = 0; i < 14; i++)
         check($sformatf("stream_byte%0d", i), {24'h0, rx_log[base + i]}, {24'h0, stream[i]});
      check("stream_ferr", ferr_cnt, 0);

      // A 5-clock low glitch.
      base = valid_cnt;
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      check("glitch_busy_hi", rx_if.rx_busy, 1'b1);
      rxd = 1'b1;
      n = 0;
      while (rx_if.rx_busy === 1'b1 && n < 12) begin
         @(negedge clk);
         n++;
      end
      check("glitch_busy_lo", rx_if.rx_busy, 1'b0);
      idle(200);
      check("glitch_valid", valid_cnt, base);
      check("glitch_ferr", ferr_cnt, 0);

      // Reset in the middle of the data bits of 0x53. The line returns to idle during reset.
      base = valid_cnt;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = stream[2][i];
         repeat (CPB) @(negedge clk);
      end
      n_rst = 1'b0;
      rxd   = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", rx_if.rx_busy, 1'b0);
      check("rst_data", {24'h0, rx_if.rx_data}, 32'h00);
      n_rst = 1'b1;
      idle(200);
      check("rst_no_pulse", valid_cnt, base);
      send_byte(8'h2D, 1'b1);
      idle(20);
      wait_count("rst_next_count", base + 1);
      check("rst_next_data", {24'h0, rx_if.rx_data}, 32'h2D);

      // Framing error, then a 40-clock break, then a good byte.
      base  = valid_cnt;
      ferr0 = ferr_cnt;
      send_byte(8'h3D, 1'b0);
      repeat (40) @(negedge clk);
      check("ferr_count", ferr_cnt, ferr0 + 1);
      check("ferr_no_valid", valid_cnt, base);
      check("ferr_data_held", {24'h0, rx_if.rx_data}, 32'h2D);
      check("ferr_break_busy", rx_if.rx_busy, 1'b1);
      idle(20);
      check("ferr_idle_busy", rx_if.rx_busy, 1'b0);
      send_byte(8'h30, 1'b1);
      idle(20);
      wait_count("ferr_next_count", base + 1);
      check("ferr_next_data", {24'h0, rx_if.rx_data}, 32'h30);
      check("ferr_total", ferr_cnt, ferr0 + 1);

      // Latency of rx_valid for 0x00 and 0xFF. The expected edge is 155, +/-1.
      base = valid_cnt;
      send_byte(8'h00, 1'b1);
      idle(20);
      wait_count("lat00_count", base + 1);
      check("lat00_edge", (last_lat >= 154 && last_lat <= 156), 1'b1);
      check("lat00_data", {24'h0, rx_if.rx_data}, 32'h00);
      send_byte(8'hFF, 1'b1);
      idle(20);
      wait_count("latff_count", base + 2);
      check("latff_edge", (last_lat >= 154 && last_lat <= 156), 1'b1);
      check("latff_data", {24'h0, rx_if.rx_data}, 32'hFF);

      check("valid_ferr_overlap", both_cnt, 0);
      check("valid_back_to_back", dbl_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
